// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter.
// Optional owner lock is enabled with REG_ARB_LOCK_EN.
package reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Pointer width; never below one bit so NREQ=2 still has a real index.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// The lock vector exists only when REG_ARB_LOCK_EN is defined.
interface reg_share_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    import reg_arb_pkg::*;

    localparam int PW = clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      dout;
    logic [PW-1:0]         owner;
    logic                  busy;
`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0]       lock;

    modport master (
        output req, din, lock,
        input  ack, dout, owner, busy
    );

    modport slave (
        input  req, din, lock,
        output ack, dout, owner, busy
    );
`else
    modport master (
        output req, din,
        input  ack, dout, owner, busy
    );

    modport slave (
        input  req, din,
        output ack, dout, owner, busy
    );
`endif

endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or above rr_ptr, wrapping modulo NREQ.
module reg_arb_rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic            grant_valid,
    output logic [PW-1:0]   grant_idx
);

    // Walk offsets from far to near so the nearest hit is the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbitrated shared register with post-write hold.
// Define REG_ARB_LOCK_EN to let a locked owner keep winning.
module reg_share_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    reg_share_arbiter_if.slave bus
);

    localparam int PW = clog2(NREQ);
    localparam logic [3:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    state_t           state_q;
    logic [3:0]       hold_q;
    logic [WIDTH-1:0] dout_q;
    logic [PW-1:0]    owner_q;
    logic [PW-1:0]    ptr_q;
    logic [NREQ-1:0]  ack_q;
    logic             busy_q;

    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic             win_valid;
    logic [PW-1:0]    win_idx;
    logic             win_adv;
    logic [PW-1:0]    ptr_d;
    logic [WIDTH-1:0] wdata;

    reg_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req         (bus.req),
        .rr_ptr      (ptr_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // Winner selection; a locked, requesting owner overrides round-robin.
    always_comb begin
        win_valid = pick_valid;
        win_idx   = pick_idx;
        win_adv   = 1'b1;
`ifdef REG_ARB_LOCK_EN
        if (bus.lock[owner_q] && bus.req[owner_q]) begin
            win_valid = 1'b1;
            win_idx   = owner_q;
            win_adv   = 1'b0;
        end
`endif
    end

    // Pointer advances past the winner, wrapping at NREQ.
    always_comb begin
        if (win_idx == PW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx + PW'(1);
        end
    end

    // Mux the winner's slice out of the packed data bus.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                wdata = bus.din[i*WIDTH +: WIDTH];
            end
        end
    end

    // IDLE/HOLD FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            dout_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        dout_q  <= wdata;
                        owner_q <= win_idx;
                        ack_q   <= NREQ'(1) << win_idx;
                        if (win_adv) begin
                            ptr_q <= ptr_d;
                        end
                        if (HOLD_CYCLES > 0) begin
                            state_q <= HOLD;
                            busy_q  <= 1'b1;
                            hold_q  <= HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.ack   = ack_q;
    assign bus.dout  = dout_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter against a behavioural model.
// Lock scenarios are exercised when REG_ARB_LOCK_EN is defined.
module tb_reg_share_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int HC    = 2;
    localparam int PW    = 2;
    localparam int DW    = NREQ * WIDTH;

    typedef struct {
        logic [NREQ-1:0]  ack;
        logic [WIDTH-1:0] dout;
        logic [PW-1:0]    owner;
        logic             busy;
    } exp_t;

    logic clk;
    logic reset;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    int               m_ptr;
    int               m_owner;
    int               m_hold;
    logic [WIDTH-1:0] m_dout;

`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0] lock_v;
`endif

    reg_share_arbiter_if #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) bus ();

    reg_share_arbiter #(
        .WIDTH       (WIDTH),
        .NREQ        (NREQ),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: register update rules stated as plain arithmetic.
    task automatic model(input logic r,
                         input logic [NREQ-1:0] rq,
                         input logic [DW-1:0] d);
        exp_t e;
        int w;
        bit adv;
        e.ack = '0;
        if (r) begin
            m_ptr   = 0;
            m_owner = 0;
            m_dout  = '0;
            m_hold  = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (rq != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (w < 0 && rq[i]) w = i;
            end
            adv = 1'b1;
`ifdef REG_ARB_LOCK_EN
            if (lock_v[m_owner] && rq[m_owner]) begin
                w   = m_owner;
                adv = 1'b0;
            end
`endif
            m_dout  = d[w*WIDTH +: WIDTH];
            m_owner = w;
            if (adv) m_ptr = (w + 1) % NREQ;
            e.ack[w] = 1'b1;
            m_hold   = HC;
        end
        e.dout  = m_dout;
        e.owner = PW'(m_owner);
        e.busy  = (m_hold > 0);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r,
                        input logic [NREQ-1:0] rq,
                        input logic [DW-1:0] d);
        reset   = r;
        bus.req = rq;
        bus.din = d;
`ifdef REG_ARB_LOCK_EN
        bus.lock = lock_v;
`endif
        model(r, rq, d);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_din();
        return DW'($urandom);
    endfunction

    // Monitor: one expected record per edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack",   32'(bus.ack),   32'(e.ack));
            chk("dout",  32'(bus.dout),  32'(e.dout));
            chk("owner", 32'(bus.owner), 32'(e.owner));
            chk("busy",  32'(bus.busy),  32'(e.busy));
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [NREQ-1:0] rq;
        checks  = 0;
        errors  = 0;
        m_ptr   = 0;
        m_owner = 0;
        m_hold  = 0;
        m_dout  = '0;
        reset   = 1'b1;
        bus.req = '0;
        bus.din = '0;
`ifdef REG_ARB_LOCK_EN
        lock_v   = '0;
        bus.lock = '0;
`endif

        // Reset with all requests high.
        step(1'b1, 4'b1111, rnd_din());
        step(1'b1, 4'b1111, rnd_din());

        // Single writer on requester 2.
        d = rnd_din();
        d[2*WIDTH +: WIDTH] = 4'b1010;
        step(1'b0, 4'b0100, d);
        repeat (3) step(1'b0, 4'b0000, rnd_din());

        // Fairness under continuous requests.
        step(1'b1, 4'b0000, '0);
        repeat (15) step(1'b0, 4'b1111, rnd_din());

        // Wrap: pointer at 3, requesters 0 and 1 pending.
        step(1'b1, 4'b0000, '0);
        step(1'b0, 4'b0100, rnd_din());
        repeat (2) step(1'b0, 4'b0000, rnd_din());
        repeat (7) step(1'b0, 4'b0011, rnd_din());

        // Reset in the first HOLD cycle, then a fresh write.
        step(1'b0, 4'b0000, rnd_din());
        step(1'b0, 4'b0000, rnd_din());
        step(1'b0, 4'b1000, rnd_din());
        step(1'b1, 4'b1000, rnd_din());
        step(1'b0, 4'b0010, rnd_din());
        repeat (3) step(1'b0, 4'b0000, rnd_din());

`ifdef REG_ARB_LOCK_EN
        // Locked owner keeps winning, then round-robin resumes.
        step(1'b1, 4'b0000, '0);
        step(1'b0, 4'b0010, rnd_din());
        repeat (2) step(1'b0, 4'b0000, rnd_din());
        lock_v = 4'b0010;
        repeat (9) step(1'b0, 4'b0011, rnd_din());
        lock_v = 4'b0000;
        repeat (3) step(1'b0, 4'b0011, rnd_din());
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rq = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
`ifdef REG_ARB_LOCK_EN
            if ($urandom_range(0, 3) == 0) begin
                lock_v = NREQ'($urandom);
            end
`endif
            step($urandom_range(0, 99) < 3, rq, rnd_din());
        end

        step(1'b0, 4'b0000, '0);
        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, 4, data width of the shared parallel-in parallel-out register.
REQ-002 Parameter NREQ SHALL be: NREQ, 4, number of requesters (2..8).
REQ-003 Parameter HOLD_CYCLES SHALL be: HOLD_CYCLES, 2, cycles the register is held stable after each write (0..15).
REQ-004 Port clk SHALL be: clk  input  1  single clock, all state updates on its rising edge.
REQ-005 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-006 Port req SHALL be: req  input  NREQ  per-requester write request, level.
REQ-007 Port din SHALL be: din  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port ack SHALL be: ack  output  NREQ  one-hot, one-cycle write-done pulse.
REQ-009 Port dout SHALL be: dout  output  WIDTH  shared register contents.
REQ-010 Port owner SHALL be: owner  output  clog2(NREQ)  index of last writer.
REQ-011 Port busy SHALL be: busy  output  1  high while in HOLD.

Function
REQ-012 FSM SHALL have two states: IDLE, HOLD.
REQ-013 In IDLE with req != 0, the winner SHALL be the first set req bit searching upward from rr_ptr, wrapping modulo NREQ.
REQ-014 At that edge, dout <= winner's din slice, owner <= winner, rr_ptr <= (winner+1) mod NREQ, ack <= one-hot(winner).
REQ-015 ack SHALL be high exactly one cycle, the cycle after the write edge; ack SHALL be 0 in all other cycles.
REQ-016 If HOLD_CYCLES > 0, write edge SHALL move IDLE->HOLD with hold counter loaded to HOLD_CYCLES-1; HOLD SHALL last exactly HOLD_CYCLES cycles, then return to IDLE.
REQ-017 If HOLD_CYCLES == 0, FSM SHALL stay in IDLE, allowing one write per cycle.
REQ-018 In HOLD, req SHALL be ignored; dout, owner, rr_ptr unchanged.
REQ-019 In IDLE with req == 0, all state SHALL be unchanged.
REQ-020 Write-to-write spacing SHALL be HOLD_CYCLES+1 cycles under continuous requests.
REQ-021 A requester dropping req during HOLD SHALL lose no state; only req at the IDLE edge counts.
REQ-022 busy SHALL equal (state == HOLD), registered.

Reset
REQ-023 reset high at an edge SHALL force state IDLE, dout 0, owner 0, rr_ptr 0, ack 0, busy 0, hold counter 0, overriding any write in that cycle, including mid-HOLD.

Configuration
REQ-024 Macro REG_ARB_LOCK_EN, when defined, SHALL add input lock (NREQ bits); if lock[owner] and req[owner] are high in IDLE, owner SHALL win regardless of rr_ptr, and rr_ptr SHALL be left unchanged.
REQ-025 Without REG_ARB_LOCK_EN, the lock port SHALL not exist and arbitration SHALL be pure round-robin per REQ-013.

Structure
REQ-026 Package reg_arb_pkg SHALL hold the state typedef (IDLE, HOLD) and the pointer-width function clog2.
REQ-027 Combinational round-robin picker SHALL be sub-module reg_arb_rr_pick (inputs req, rr_ptr; outputs grant_valid, grant_idx).

Verification
REQ-028 Reset: reset=1 one cycle with req=4'b1111 -> dout=0, ack=0, owner=0, busy=0 next cycle.
REQ-029 Single writer: req=4'b0100, din slice 2=4'b1010 -> next cycle dout=4'b1010, ack=4'b0100, owner=2, busy=1 for 2 cycles.
REQ-030 Fairness: req=4'b1111 held, HOLD_CYCLES=2 -> ack sequence 0001,0010,0100,1000,0001, spaced 3 cycles apart.
REQ-031 Wrap: rr_ptr=3, req=4'b0011 -> requester 0 wins, then requester 1.
REQ-032 Mid-HOLD reset: reset asserted in 1st HOLD cycle -> next cycle IDLE, dout=0, and with req=4'b0010 the following write grants requester 1.
REQ-033 Lock (REG_ARB_LOCK_EN): owner=1, lock=4'b0010, req=4'b0011 -> requester 1 wins three consecutive grants; lock=0 -> next grant to requester 0.
